// File: rtl/truth_table_engine.sv
// Programmable truth-table evaluator.
// Holds a 2^N_IN-bit table that can be reloaded at run time, evaluates single
// input vectors through a one-entry registered output, and can sweep every
// input combination while counting how many of them evaluate to 1.
//
// Handshakes: every channel (cfg, in, out) transfers a beat on a rising clock
// edge where valid and ready are both high. A valid is held until it is taken;
// ready may depend combinationally on the other side's valid in this block
// (cfg_valid and sweep_start mask in_ready so config always wins).
module truth_table_engine #(
    parameter int                   N_IN    = 3,
    parameter logic [(1<<N_IN)-1:0] TT_INIT = 8'h40
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [(1<<N_IN)-1:0]  cfg_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_IN-1:0]       in_bits,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_bit,
    output logic [N_IN-1:0]       out_tag,
    input  logic                  sweep_start,
    output logic                  sweep_busy,
    output logic                  sweep_done,
    output logic [N_IN:0]         ones_count
);

    localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t               state;
    logic [(1<<N_IN)-1:0] tt;
    logic [N_IN-1:0]      idx;
    logic [N_IN:0]        count;
    logic                 issued_last;

    logic out_free;
    logic cfg_fire;
    logic in_fire;
    logic start_fire;
    logic sweep_load;
    logic sweep_end;
    logic in_lookup;
    logic idx_lookup;

    // Handshake qualifiers and table lookups. The table MSB belongs to input
    // vector 0, so the bit index for vector v is (2^N_IN-1-v), i.e. ~v.
    always_comb begin
        out_free   = !out_valid || out_ready;
        cfg_ready  = (state == IDLE) && !out_valid;
        in_ready   = (state == IDLE) && !cfg_valid && !sweep_start && out_free;
        cfg_fire   = cfg_valid && cfg_ready;
        in_fire    = in_valid && in_ready;
        start_fire = (state == IDLE) && sweep_start && !cfg_valid && !out_valid;
        sweep_load = (state == SWEEP) && out_free && !issued_last;
        sweep_end  = (state == SWEEP) && issued_last && out_valid && out_ready;
        in_lookup  = tt[~in_bits];
        idx_lookup = tt[~idx];
    end

    // Control FSM, table register, output register and sweep bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tt          <= TT_INIT;
            idx         <= '0;
            count       <= '0;
            issued_last <= 1'b0;
            out_valid   <= 1'b0;
            out_bit     <= 1'b0;
            out_tag     <= '0;
            sweep_busy  <= 1'b0;
            sweep_done  <= 1'b0;
            ones_count  <= '0;
        end else begin
            sweep_done <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (cfg_fire) begin
                        tt <= cfg_data;
                    end else if (in_fire) begin
                        out_valid <= 1'b1;
                        out_bit   <= in_lookup;
                        out_tag   <= in_bits;
                    end else if (start_fire) begin
                        state       <= SWEEP;
                        sweep_busy  <= 1'b1;
                        idx         <= '0;
                        count       <= '0;
                        issued_last <= 1'b0;
                    end
                end
                SWEEP: begin
                    if (sweep_load) begin
                        out_valid <= 1'b1;
                        out_bit   <= idx_lookup;
                        out_tag   <= idx;
                        count     <= count + {{N_IN{1'b0}}, idx_lookup};
                        // idx parks on the last vector; issued_last stops reloads.
                        if (idx == IDX_LAST) begin
                            issued_last <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    if (sweep_end) begin
                        state      <= IDLE;
                        sweep_busy <= 1'b0;
                        sweep_done <= 1'b1;
                        ones_count <= count;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_engine.sv
// Bench for truth_table_engine (N_IN=3, default table 8'h40).
module tb_truth_table_engine;

    logic       clk;
    logic       rst_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_data;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_bits;
    logic       out_valid;
    logic       out_ready;
    logic       out_bit;
    logic [2:0] out_tag;
    logic       sweep_start;
    logic       sweep_busy;
    logic       sweep_done;
    logic [3:0] ones_count;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0] m_tt;
    logic       m_pend;
    logic       m_bit;
    logic [2:0] m_tag;

    truth_table_engine #(.N_IN(3), .TT_INIT(8'h40)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
        .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit), .out_tag(out_tag),
        .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
        .ones_count(ones_count)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       cv;
        logic [7:0] cd;
        logic       iv;
        logic [2:0] ib;
        logic       ss;
        logic       ordy;
        logic       e_cr;
        logic       e_ir;
        logic       e_ov;
        logic       e_ob;
        logic [2:0] e_ot;
        logic       e_busy;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Tag v evaluates to table bit number (7 - v): MSB is vector 0.
    function automatic logic ref_lookup(input logic [7:0] t, input int v);
        logic [7:0] sh;
        sh = t >> (7 - v);
        return sh[0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cfg_valid   = 1'b0;
        cfg_data    = 8'h00;
        in_valid    = 1'b0;
        in_bits     = 3'd0;
        sweep_start = 1'b0;
        out_ready   = 1'b1;
    endtask

    task automatic load_cfg(input logic [7:0] d);
        idle_inputs();
        cfg_valid = 1'b1;
        cfg_data  = d;
        #1;
        chk("load_cfg_ready", cfg_ready, 1'b1);
        step();
        cfg_valid = 1'b0;
        m_tt = d;
    endtask

    // Sweep with out_ready pattern: 0 always 1, 1 toggling, 2 random.
    task automatic run_sweep(input int mode);
        logic [3:0] exp_q[$];
        logic [3:0] prev;
        logic [3:0] act;
        logic       prev_stall;
        int         ones;
        int         cyc;
        ones = 0;
        for (int v = 0; v < 8; v++) begin
            exp_q.push_back({ref_lookup(m_tt, v), 3'(v)});
            ones += int'(ref_lookup(m_tt, v));
        end
        idle_inputs();
        sweep_start = 1'b1;
        #1;
        chk("start_in_ready", in_ready, 1'b0);
        step();
        sweep_start = 1'b0;
        chk("start_busy", sweep_busy, 1'b1);
        chk("start_out_valid", out_valid, 1'b0);
        cyc = 0;
        prev_stall = 1'b0;
        prev = 4'h0;
        while (exp_q.size() > 0 && cyc < 100) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 1);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            chk("sweep_cfg_ready", cfg_ready, 1'b0);
            chk("sweep_in_ready", in_ready, 1'b0);
            chk("sweep_busy_mid", sweep_busy, 1'b1);
            chk("sweep_done_early", sweep_done, 1'b0);
            if (prev_stall) chk("sweep_hold", {out_bit, out_tag}, prev);
            if (out_valid && out_ready) begin
                act = {out_bit, out_tag};
                chk("sweep_beat", act, exp_q.pop_front());
            end
            prev_stall = out_valid && !out_ready;
            prev = {out_bit, out_tag};
            step();
            cyc++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sweep_timeout remaining=%0d expected=0", exp_q.size());
        end
        if (mode == 0) chk("sweep_cycles", cyc, 9);
        out_ready = 1'b1;
        chk("sweep_done_pulse", sweep_done, 1'b1);
        chk("sweep_busy_end", sweep_busy, 1'b0);
        chk("sweep_ones", ones_count, ones);
        chk("sweep_out_valid_end", out_valid, 1'b0);
        step();
        chk("sweep_done_clear", sweep_done, 1'b0);
        chk("sweep_ones_hold", ones_count, ones);
    endtask

    task automatic eval_one(input logic [2:0] v, input logic e_bit);
        idle_inputs();
        in_valid = 1'b1;
        in_bits  = v;
        #1;
        chk("eval_in_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        chk("eval_valid", out_valid, 1'b1);
        chk("eval_bit", out_bit, e_bit);
        chk("eval_tag", out_tag, v);
        step();
    endtask

    initial begin
        logic e_cr;
        logic e_ir;
        bit   seen;
        // stimulus table: directed handshake and priority cases
        //          cv cd     iv ib ss or  cr ir  ov ob ot busy
        vecs[0]  = '{1'b0, 8'h00, 1'b1, 3'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
        vecs[3]  = '{1'b1, 8'hFE, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0};
        vecs[6]  = '{1'b1, 8'h40, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 3'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd7, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
        vecs[9]  = '{1'b1, 8'h40, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0};

        // reset
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_bit", out_bit, 1'b0);
        chk("rst_out_tag", out_tag, 3'd0);
        chk("rst_busy", sweep_busy, 1'b0);
        chk("rst_done", sweep_done, 1'b0);
        chk("rst_ones", ones_count, 4'd0);
        chk("rst_cfg_ready", cfg_ready, 1'b1);
        chk("rst_in_ready", in_ready, 1'b1);
        step();

        // directed vector table
        for (int i = 0; i < 13; i++) begin
            cfg_valid   = vecs[i].cv;
            cfg_data    = vecs[i].cd;
            in_valid    = vecs[i].iv;
            in_bits     = vecs[i].ib;
            sweep_start = vecs[i].ss;
            out_ready   = vecs[i].ordy;
            #1;
            chk($sformatf("vec%0d_cfg_ready", i), cfg_ready, vecs[i].e_cr);
            chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_ir);
            step();
            chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_ov);
            if (vecs[i].e_ov) begin
                chk($sformatf("vec%0d_out_bit", i), out_bit, vecs[i].e_ob);
                chk($sformatf("vec%0d_out_tag", i), out_tag, vecs[i].e_ot);
            end
            chk($sformatf("vec%0d_busy", i), sweep_busy, vecs[i].e_busy);
        end
        m_tt   = 8'h40;
        m_pend = 1'b0;
        m_bit  = 1'b0;
        m_tag  = 3'd0;

        // sweeps on the default table: full rate, then toggling backpressure
        run_sweep(0);
        run_sweep(1);

        // randomized config/evaluation traffic against the model
        for (int c = 0; c < 400; c++) begin
            cfg_valid   = ($urandom_range(0, 7) == 0);
            cfg_data    = 8'($urandom);
            in_valid    = 1'($urandom_range(0, 1));
            in_bits     = 3'($urandom);
            out_ready   = 1'($urandom_range(0, 1));
            sweep_start = 1'b0;
            #1;
            e_cr = !m_pend;
            e_ir = !cfg_valid && (!m_pend || out_ready);
            chk("rnd_cfg_ready", cfg_ready, e_cr);
            chk("rnd_in_ready", in_ready, e_ir);
            if (m_pend && out_ready) m_pend = 1'b0;
            if (cfg_valid && e_cr) begin
                m_tt = cfg_data;
            end else if (in_valid && e_ir) begin
                m_pend = 1'b1;
                m_bit  = ref_lookup(m_tt, int'(in_bits));
                m_tag  = in_bits;
            end
            step();
            chk("rnd_out_valid", out_valid, m_pend);
            if (m_pend) begin
                chk("rnd_out_bit", out_bit, m_bit);
                chk("rnd_out_tag", out_tag, m_tag);
            end
        end
        idle_inputs();
        step();
        m_pend = 1'b0;
        chk("drain_out_valid", out_valid, 1'b0);

        // sweep on whatever table the random traffic left, random backpressure
        run_sweep(2);
        // boundary tables: no ones, all ones
        load_cfg(8'h00);
        run_sweep(0);
        load_cfg(8'hFF);
        run_sweep(1);

        // reset in the middle of a sweep
        idle_inputs();
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            if (out_valid && out_tag == 3'd4) seen = 1'b1;
            else step();
        end
        chk("mid_reset_reached_tag4", seen, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_out_valid", out_valid, 1'b0);
        chk("mid_reset_busy", sweep_busy, 1'b0);
        chk("mid_reset_done", sweep_done, 1'b0);
        chk("mid_reset_ones", ones_count, 4'd0);
        chk("mid_reset_tag", out_tag, 3'd0);
        step();
        rst_n = 1'b1;
        m_tt = 8'h40;
        #1;
        chk("post_reset_done", sweep_done, 1'b0);
        chk("post_reset_busy", sweep_busy, 1'b0);
        eval_one(3'd1, ref_lookup(m_tt, 1));
        eval_one(3'd0, ref_lookup(m_tt, 0));
        chk("post_reset_done_late", sweep_done, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/truth_table_engine.md
Name: truth_table_engine

Overview:
- Parametrised, programmable successor to the fixed 3-input truth-table gate modules.
- Holds a 2^N_IN-bit truth table in a register that reloads at run time, and evaluates input vectors through a valid/ready pipeline with a registered output.
- Has an autonomous sweep mode that enumerates every input combination and counts the ones.
- Sits between the stimulus/config source and the circuit-scoring logic.

Parameters:
- N_IN, 3, number of logic inputs (1..8).
- TT_INIT, 8'h40, truth table loaded at reset. Width is 2^N_IN bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- cfg_valid  input  1  new truth table offered
- cfg_ready  output  1  engine can accept a table
- cfg_data  input  2^N_IN  truth table to load
- in_valid  input  1  input vector offered
- in_ready  output  1  engine accepts the vector
- in_bits  input  N_IN  input vector; in_bits[N_IN-1] is in1 (MSB)
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts the beat
- out_bit  output  1  evaluated logic value
- out_tag  output  N_IN  input vector that produced out_bit
- sweep_start  input  1  single-cycle request to enumerate all inputs
- sweep_busy  output  1  high while in SWEEP
- sweep_done  output  1  one-cycle pulse when the sweep completes
- ones_count  output  N_IN+1  number of 1 outputs in the last sweep

Behaviour:
- Lookup convention: out_bit = tt[2^N_IN-1-v], where v is the unsigned input vector. The MSB of the table corresponds to input 0.
  - Example: tt=8'h40 gives 1 only for v=3'b001.
- Reset (async, rst_n=0) values:
  - tt=TT_INIT, state=IDLE.
  - out_valid=0, out_bit=0, out_tag=0.
  - sweep_busy=0, sweep_done=0, ones_count=0.
  - Sweep counter = 0.
  - Reset mid-sweep or with a beat pending aborts everything. No sweep_done is emitted.
- States:
  - IDLE: serves config, single evaluations and sweep start.
  - SWEEP: enumerates inputs; cfg_ready=0 and in_ready=0 here.
- Output register: single entry.
  - Cleared when out_valid && out_ready.
  - out_bit and out_tag hold stable while out_valid=1 && out_ready=0.
- Config:
  - cfg_ready = IDLE && !out_valid.
  - On a cfg handshake, tt takes cfg_data at the clock edge and is used from the next cycle.
- Evaluation:
  - in_ready = IDLE && !cfg_valid && !sweep_start && (!out_valid || out_ready). Config has priority over evaluation.
  - On an in handshake the beat is registered: latency 1 cycle.
  - Back-to-back accepts give 1 beat/cycle when out_ready=1.
- Sweep start:
  - sweep_start is honoured only when IDLE && !out_valid && !cfg_valid. Otherwise it is ignored (not queued).
  - Accepted start: state goes to SWEEP, idx=0, internal count=0, sweep_busy=1 next cycle.
- Sweep enumeration:
  - Each cycle in SWEEP with the output register free or draining: load out_bit=lookup(idx), out_tag=idx, count += lookup(idx).
  - idx then increments; it never wraps past 2^N_IN-1.
  - Backpressure stalls idx.
- Sweep completion:
  - When the beat for idx=2^N_IN-1 is accepted downstream: ones_count = final count (0..2^N_IN), sweep_done pulses for 1 cycle, state goes to IDLE, sweep_busy=0 in the same cycle.
- ones_count holds until the next sweep completes or reset.
- Simultaneous events in IDLE: cfg beats evaluate beats beats sweep_start, and only one is accepted per cycle.
- A new table takes effect only for vectors accepted after the load cycle.

Test Plan:
- Reset, N_IN=3, default table: evaluate 3'b001 then 3'b010 with out_ready=1 → out_bit=1 (tag 1) then 0 (tag 2), each 1 cycle after accept.
- Load cfg_data=8'hFE, then evaluate 3'b000 and 3'b111 → out_bit 1 then 0. cfg_ready=0 while a beat is pending.
- sweep_start with table 8'h40, out_ready=1 → 8 beats, tags 0..7, bits 0,1,0,0,0,0,0,0. sweep_done 1 cycle after the last beat; ones_count=1.
- Sweep with out_ready toggling 1/0 every cycle → same 8 beats in order, no drops or duplicates, out_bit/out_tag stable while stalled.
- cfg_valid, in_valid and sweep_start all high in one IDLE cycle → only the config is accepted; in_ready=0 and the sweep is not started.
- Assert rst_n=0 at tag 4 mid-sweep → immediately out_valid=0, sweep_busy=0, tt=8'h40, no sweep_done, ones_count=0.
